// File: rtl/fetch_pkg.sv
// fetch_pkg: widths and the entry record shared by the fetch queue and its
// storage array.
//   PC_W       : program counter width
//   INSTR_W    : instruction word width
//   fq_entry_t : one buffered {pc, instr} pair
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry register array for the fetch queue.
//   clk     : system clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i (combinational read)
// The array has no reset; the queue control never exposes an entry that was
// not written since the last reset or flush.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  fq_entry_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output fq_entry_t       rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // First-word-fall-through: the head is visible without a read cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   enq_valid_F  : fetch presents an instruction
//   enq_pc_F     : PC of the presented instruction
//   enq_instr_F  : presented instruction word
//   enq_ready_F  : queue can accept (gates the fetch PC register)
//   flush_F      : redirect; discards every buffered entry
//   deq_valid_D  : head entry valid for decode
//   deq_pc_D     : head PC (0 when not valid)
//   deq_instr_D  : head instruction (0 when not valid)
//   deq_ready_D  : decode consumes the head
//   count        : number of occupied entries
// PC_W / INSTR_W must match the widths in fetch_pkg, which size the entries.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid_F,
  input  logic [PC_W-1:0]          enq_pc_F,
  input  logic [INSTR_W-1:0]       enq_instr_F,
  output logic                     enq_ready_F,
  input  logic                     flush_F,
  output logic                     deq_valid_D,
  output logic [PC_W-1:0]          deq_pc_D,
  output logic [INSTR_W-1:0]       deq_instr_D,
  input  logic                     deq_ready_D,
  output logic [$clog2(DEPTH):0]   count
);
  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic      enq_fire;
  logic      deq_fire;
  fq_entry_t wr_entry;
  fq_entry_t rd_entry;

  // Ready/valid come only from the registered count, so deq_ready_D has no
  // combinational path to enq_ready_F and a full queue never bypasses.
  assign enq_ready_F = (count_q != CW'(DEPTH));
  assign deq_valid_D = (count_q != '0);
  assign count       = count_q;

  assign enq_fire = enq_valid_F & enq_ready_F & ~flush_F;
  assign deq_fire = deq_valid_D & deq_ready_D & ~flush_F;

  assign wr_entry.pc    = enq_pc_F;
  assign wr_entry.instr = enq_instr_F;

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .we_i    (enq_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Stale storage must never leak to decode.
  assign deq_pc_D    = deq_valid_D ? rd_entry.pc    : '0;
  assign deq_instr_D = deq_valid_D ? rd_entry.instr : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_F) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous enq+deq leaves the occupancy unchanged.
      if (enq_fire && !deq_fire) begin
        count_d = count_q + CW'(1);
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] IBASE = 32'h8B1F03E0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enq_valid_F;
  logic [PC_W-1:0]     enq_pc_F;
  logic [INSTR_W-1:0]  enq_instr_F;
  logic                enq_ready_F;
  logic                flush_F;
  logic                deq_valid_D;
  logic [PC_W-1:0]     deq_pc_D;
  logic [INSTR_W-1:0]  deq_instr_D;
  logic                deq_ready_D;
  logic [2:0]          count;

  int checks = 0;
  int fails  = 0;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .enq_valid_F (enq_valid_F),
    .enq_pc_F    (enq_pc_F),
    .enq_instr_F (enq_instr_F),
    .enq_ready_F (enq_ready_F),
    .flush_F     (flush_F),
    .deq_valid_D (deq_valid_D),
    .deq_pc_D    (deq_pc_D),
    .deq_instr_D (deq_instr_D),
    .deq_ready_D (deq_ready_D),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] ins, input logic dr,
                       input logic fl);
    enq_valid_F = ev;
    enq_pc_F    = pc;
    enq_instr_F = ins;
    deq_ready_D = dr;
    flush_F     = fl;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0 || deq_valid_D !== 1'b0 || enq_ready_F !== 1'b1 ||
        deq_pc_D !== 64'd0 || deq_instr_D !== 32'd0) begin
      fails++;
      $display("FAIL reset_idle: count=%0d valid=%b ready=%b pc=%h instr=%h, need 0 0 1 0 0",
               count, deq_valid_D, enq_ready_F, deq_pc_D, deq_instr_D);
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h500 + 64'(4 * k), IBASE + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      fails++;
      $display("FAIL midrst_pre_count: got %0d need 3", count);
    end
    #2;                 // well away from any clock edge
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || deq_valid_D !== 1'b0 || enq_ready_F !== 1'b1 ||
        deq_pc_D !== 64'd0) begin
      fails++;
      $display("FAIL midrst_async: count=%0d valid=%b ready=%b pc=%h, need 0 0 1 0",
               count, deq_valid_D, enq_ready_F, deq_pc_D);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'(4 * k), IBASE + 32'(k), 1'b0, 1'b0);
      tick();
      checks++;
      if (count !== 3'(k + 1)) begin
        fails++;
        $display("FAIL fill_count k=%0d: got %0d need %0d", k, count, k + 1);
      end
    end
    checks++;
    if (enq_ready_F !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b need 0", enq_ready_F);
    end
    drive(1'b1, 64'h10, IBASE + 32'd4, 1'b0, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4 || deq_pc_D !== 64'h0) begin
      fails++;
      $display("FAIL fifth_rejected: count=%0d head=%h, need 4 0", count, deq_pc_D);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      $display("deq pc=%h instr=%h", deq_pc_D, deq_instr_D);
      checks++;
      if (deq_valid_D !== 1'b1 || deq_pc_D !== 64'(4 * k) ||
          deq_instr_D !== IBASE + 32'(k)) begin
        fails++;
        $display("FAIL drain k=%0d: valid=%b pc=%h instr=%h, need 1 %h %h",
                 k, deq_valid_D, deq_pc_D, deq_instr_D, 64'(4 * k), IBASE + 32'(k));
      end
      tick();
    end
    checks++;
    if (deq_valid_D !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL drained_empty: valid=%b count=%0d, need 0 0", deq_valid_D, count);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    drive(1'b1, 64'h1000, IBASE, 1'b1, 1'b0);
    // No bypass: the first entry is not dequeued in its own enqueue cycle.
    checks++;
    if (deq_valid_D !== 1'b0) begin
      fails++;
      $display("FAIL stream_no_bypass: valid=%b need 0", deq_valid_D);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      $display("deq pc=%h instr=%h", deq_pc_D, deq_instr_D);
      checks++;
      if (count !== 3'd1 || deq_pc_D !== 64'h1000 + 64'(4 * k) ||
          deq_instr_D !== IBASE + 32'(k)) begin
        fails++;
        $display("FAIL stream k=%0d: count=%0d pc=%h instr=%h, need 1 %h %h",
                 k, count, deq_pc_D, deq_instr_D, 64'h1000 + 64'(4 * k), IBASE + 32'(k));
      end
      if (k < 9) drive(1'b1, 64'h1000 + 64'(4 * (k + 1)), IBASE + 32'(k + 1), 1'b1, 1'b0);
      else       drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL stream_end_count: got %0d need 0", count);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] exp_pc [4];
    exp_pc[0] = 64'h104; exp_pc[1] = 64'h108; exp_pc[2] = 64'h10C; exp_pc[3] = 64'h200;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'h100 + 64'(4 * k), IBASE + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h200, 32'hCAFE0200, 1'b1, 1'b0);
    tick();
    checks++;
    if (count !== 3'd3 || deq_pc_D !== 64'h104) begin
      fails++;
      $display("FAIL full_enq_deq: count=%0d head=%h, need 3 104", count, deq_pc_D);
    end
    drive(1'b1, 64'h200, 32'hCAFE0200, 1'b0, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4 || enq_ready_F !== 1'b0) begin
      fails++;
      $display("FAIL retry_accept: count=%0d ready=%b, need 4 0", count, enq_ready_F);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      $display("deq pc=%h instr=%h", deq_pc_D, deq_instr_D);
      checks++;
      if (deq_pc_D !== exp_pc[k]) begin
        fails++;
        $display("FAIL b2b_order k=%0d: got %h need %h", k, deq_pc_D, exp_pc[k]);
      end
      tick();
    end
    checks++;
    if (deq_instr_D !== 32'd0 || deq_valid_D !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: valid=%b instr=%h, need 0 0", deq_valid_D, deq_instr_D);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 64'(4 * k), IBASE + 32'(k), 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      $display("deq pc=%h instr=%h", deq_pc_D, deq_instr_D);
      checks++;
      if (deq_valid_D !== 1'b1 || deq_pc_D !== 64'(4 * k) ||
          deq_instr_D !== IBASE + 32'(k)) begin
        fails++;
        $display("FAIL wrap k=%0d: valid=%b pc=%h instr=%h, need 1 %h %h",
                 k, deq_valid_D, deq_pc_D, deq_instr_D, 64'(4 * k), IBASE + 32'(k));
      end
      tick();
    end
    checks++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL wrap_end_count: got %0d need 0", count);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h300 + 64'(4 * k), IBASE + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h400, 32'h0BAD0400, 1'b1, 1'b1);
    tick();
    checks++;
    if (count !== 3'd0 || deq_valid_D !== 1'b0 || enq_ready_F !== 1'b1) begin
      fails++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, need 0 0 1",
               count, deq_valid_D, enq_ready_F);
    end
    drive(1'b1, 64'hD8, 32'h12345678, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    $display("deq pc=%h instr=%h", deq_pc_D, deq_instr_D);
    checks++;
    if (count !== 3'd1 || deq_pc_D !== 64'hD8 || deq_instr_D !== 32'h12345678) begin
      fails++;
      $display("FAIL post_flush_head: count=%0d pc=%h instr=%h, need 1 d8 12345678",
               count, deq_pc_D, deq_instr_D);
    end
    tick();
    checks++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL post_flush_drain: got %0d need 0", count);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_fill_drain();
    test_stream();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and decode.
- Buffers {PC, instruction} pairs produced by fetch, so fetch keeps running while decode stalls.
- Back-pressures fetch through enq_ready_F, which gates the PC register enable.
- Discards all buffered entries on a redirect (taken branch or exception entry).

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enq_valid_F  input  1  fetch presents a valid instruction this cycle.
- enq_pc_F  input  PC_W  PC of the presented instruction (imem_addr_F).
- enq_instr_F  input  INSTR_W  instruction word read from imem.
- enq_ready_F  output  1  queue can accept this cycle; fetch holds its PC when low.
- flush_F  input  1  redirect; driven as PCSrc_F OR EProc_F.
- deq_valid_D  output  1  head entry valid for decode.
- deq_pc_D  output  PC_W  head entry PC.
- deq_instr_D  output  INSTR_W  head entry instruction.
- deq_ready_D  input  1  decode consumes the head this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (reset=0, asynchronous, any cycle including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0.
  - deq_valid_D=0, deq_pc_D=0, deq_instr_D=0, enq_ready_F=1.
  - Storage contents are don't-care.
- Enqueue fires on a rising edge when enq_valid_F & enq_ready_F & !flush_F.
  - Writes {enq_pc_F, enq_instr_F} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Dequeue fires on a rising edge when deq_valid_D & deq_ready_D & !flush_F; rd_ptr increments modulo DEPTH.
- enq_ready_F = (count != DEPTH). Combinational from registered count; no dependence on deq_ready_D.
- A full queue rejects enqueue even if a dequeue happens in the same cycle (no full-bypass).
- deq_valid_D = (count != 0).
- deq_pc_D and deq_instr_D:
  - When valid: show the entry at rd_ptr (first-word-fall-through, combinational read of registered storage).
  - When invalid: forced to 0.
- Latency: an enqueue at edge N makes the entry visible on deq_* after edge N. There is no same-cycle enq-to-deq bypass, including when empty.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Flush (sampled at the edge):
  - wr_ptr, rd_ptr and count return to 0.
  - Any enqueue or dequeue in that cycle is suppressed.
  - Flush takes priority over everything except reset.
  - Next cycle: deq_valid_D=0, enq_ready_F=1.
- Wrap-around: pointers are log2(DEPTH) bits and roll over naturally. count is a separate register in 0..DEPTH and never over- or underflows.
- Protocol violations (enq_valid_F while enq_ready_F=0, or deq_ready_D while deq_valid_D=0) leave state unchanged.
- No combinational path from deq_ready_D to enq_ready_F.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_W and INSTR_W constants.
  - Packed struct fq_entry_t {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;}.
- One sub-module, fq_storage: DEPTH x fq_entry_t register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset on the array.
- Pointer, count and flush control stay in fetch_queue.

Test Plan:
- Reset then idle → count=0, deq_valid_D=0, enq_ready_F=1, deq_pc_D=0. Assert reset mid-stream with count=3 → all outputs return to reset values immediately, without waiting for a clock.
- Enqueue PC 0x00,0x04,0x08,0x0C (instr 0x8B1F03E0+k) with deq_ready_D=0 → count=4, enq_ready_F=0. A 5th enq_valid_F is rejected. Then deq_ready_D=1 for 4 cycles → PCs 0x00..0x0C appear in order, then deq_valid_D=0.
- Continuous enq and deq from empty, 10 instructions → each PC appears on deq_pc_D one cycle after its enqueue, and count stays at 1.
- Full queue with deq_ready_D=1 and enq_valid_F=1 in the same cycle → dequeue happens, enqueue rejected, count=3. Next cycle the enqueue is accepted and count=4.
- Wrap-around: 9 single enq/deq pairs at DEPTH=4 → pointers wrap twice, and data integrity holds (PC 0x20 is dequeued with its own instruction word).
- Flush with count=3, plus enq_valid_F=1 and deq_ready_D=1 in the flush cycle → next cycle count=0 and deq_valid_D=0. An enqueue of EVAddr 0xD8 the following cycle is dequeued as the first entry.
